// File: rtl/issue_allocator.sv
// In-order dispatch queue that issues at most one instruction per cycle to a free ALU,
// load/store or branch unit, forwarding write-back results into queued operands.
module issue_allocator #(
    parameter int unsigned NUM_ALU = 2,
    parameter int unsigned NUM_WB  = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_op,
    input  logic [31:0]           in_pc,
    input  logic [31:0]           in_imm,
    input  logic [31:0]           in_datax,
    input  logic [31:0]           in_datay,
    input  logic [TAG_W-1:0]      in_tagx,
    input  logic [TAG_W-1:0]      in_tagy,
    input  logic [TAG_W-1:0]      in_tagw,
    input  logic [4:0]            in_addrx,
    input  logic [4:0]            in_addry,
    input  logic [4:0]            in_addrw,
    input  logic [NUM_WB-1:0]     wb_en,
    input  logic [5*NUM_WB-1:0]   wb_addr,
    input  logic [32*NUM_WB-1:0]  wb_data,
    input  logic [NUM_ALU-1:0]    alu_busy,
    input  logic                  ls_busy,
    input  logic                  br_busy,
    output logic [NUM_ALU+1:0]    iss_en,
    output logic [3:0]            iss_op,
    output logic [31:0]           iss_pc,
    output logic [31:0]           iss_imm,
    output logic [31:0]           iss_datax,
    output logic [31:0]           iss_datay,
    output logic [TAG_W-1:0]      iss_tagx,
    output logic [TAG_W-1:0]      iss_tagy,
    output logic [TAG_W-1:0]      iss_tagw,
    output logic [4:0]            iss_addrx,
    output logic [4:0]            iss_addry,
    output logic [4:0]            iss_addrw,
    output logic                  ren_en,
    output logic [4:0]            ren_addr,
    output logic [TAG_W-1:0]      ren_tag
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
    localparam int unsigned NU    = NUM_ALU + 2;

    typedef struct packed {
        logic [7:0]       op;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [31:0]      datax;
        logic [31:0]      datay;
        logic [TAG_W-1:0] tagx;
        logic [TAG_W-1:0] tagy;
        logic [TAG_W-1:0] tagw;
        logic [4:0]       addrx;
        logic [4:0]       addry;
        logic [4:0]       addrw;
    } entry_t;

    // Lowest-numbered matching port wins for data; any match clears the tag.
    function automatic entry_t fwd(input entry_t e, input logic [NUM_WB-1:0] en,
                                   input logic [5*NUM_WB-1:0] addr,
                                   input logic [32*NUM_WB-1:0] data);
        entry_t r;
        logic   hx;
        logic   hy;
        r  = e;
        hx = 1'b0;
        hy = 1'b0;
        for (int i = 0; i < int'(NUM_WB); i++) begin
            if (en[i] && addr[5*i +: 5] == e.addrx && e.addrx != '0 && e.tagx != '0 && !hx) begin
                r.datax = data[32*i +: 32];
                r.tagx  = '0;
                hx      = 1'b1;
            end
            if (en[i] && addr[5*i +: 5] == e.addry && e.addry != '0 && e.tagy != '0 && !hy) begin
                r.datay = data[32*i +: 32];
                r.tagy  = '0;
                hy      = 1'b1;
            end
            if (en[i] && addr[5*i +: 5] == e.addrw && e.addrw != '0 && e.tagw != '0) begin
                r.tagw = '0;
            end
        end
        return r;
    endfunction

    entry_t            q [DEPTH];
    entry_t            q_snoop [DEPTH];
    entry_t            in_entry;
    entry_t            in_fwd;
    entry_t            head_fwd;
    entry_t            iss_payload;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [RR_W-1:0]   rr_q;
    logic [RR_W-1:0]   rr_d;
    logic [NU-1:0]     iss_en_d;
    logic              ren_en_d;
    logic [TAG_W-1:0]  ren_tag_d;
    logic              push;
    logic              pop;
    logic              alu_iss;
    logic              alu_found;
    int                alu_idx;
    int                alu_sel;

    assign in_entry = '{op: in_op, pc: in_pc, imm: in_imm, datax: in_datax, datay: in_datay,
                        tagx: in_tagx, tagy: in_tagy, tagw: in_tagw,
                        addrx: in_addrx, addry: in_addry, addrw: in_addrw};
    assign in_ready = (count_q < CNT_W'(DEPTH));

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            q_snoop[i] = fwd(q[i], wb_en, wb_addr, wb_data);
        end
        in_fwd    = fwd(in_entry, wb_en, wb_addr, wb_data);
        head_fwd  = q_snoop[head_q];
        iss_payload = head_fwd;
        iss_en_d  = '0;
        ren_en_d  = 1'b0;
        ren_tag_d = '0;
        pop       = 1'b0;
        alu_iss   = 1'b0;
        alu_found = 1'b0;
        alu_idx   = 0;
        alu_sel   = 0;
        for (int j = 0; j < int'(NUM_ALU); j++) begin
            alu_idx = (int'(rr_q) + j) % int'(NUM_ALU);
            if (!alu_found && !alu_busy[alu_idx]) begin
                alu_found = 1'b1;
                alu_sel   = alu_idx;
            end
        end
        rr_d = RR_W'((alu_sel + 1) % int'(NUM_ALU));
        if (count_q != '0 && !flush) begin
            case (head_fwd.op[7:4])
                4'b0001, 4'b0010, 4'b0101, 4'b1101: begin
                    if (alu_found) begin
                        pop       = 1'b1;
                        alu_iss   = 1'b1;
                        iss_en_d  = NU'(1) << alu_sel;
                        ren_en_d  = 1'b1;
                        ren_tag_d = TAG_W'(alu_sel + 1);
                    end
                end
                4'b1001: begin
                    if (!ls_busy) begin
                        pop       = 1'b1;
                        iss_en_d  = NU'(1) << NUM_ALU;
                        ren_en_d  = 1'b1;
                        ren_tag_d = TAG_W'(NUM_ALU + 1);
                    end
                end
                4'b0011: begin
                    if (!ls_busy) begin
                        pop              = 1'b1;
                        iss_en_d         = NU'(1) << NUM_ALU;
                        iss_payload.tagw = '0;
                    end
                end
                4'b0100: begin
                    if (!br_busy) begin
                        pop      = 1'b1;
                        iss_en_d = NU'(1) << (NUM_ALU + 1);
                    end
                end
                default: pop = 1'b1;
            endcase
        end
        push = in_valid && in_ready && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rr_q      <= '0;
            iss_en    <= '0;
            ren_en    <= 1'b0;
            ren_addr  <= '0;
            ren_tag   <= '0;
            iss_op    <= '0;
            iss_pc    <= '0;
            iss_imm   <= '0;
            iss_datax <= '0;
            iss_datay <= '0;
            iss_tagx  <= '0;
            iss_tagy  <= '0;
            iss_tagw  <= '0;
            iss_addrx <= '0;
            iss_addry <= '0;
            iss_addrw <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q[i] <= q_snoop[i];
            end
            if (push) begin
                q[tail_q] <= in_fwd;
            end
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_q + PTR_W'(pop);
                tail_q  <= tail_q + PTR_W'(push);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
            iss_en <= iss_en_d;
            ren_en <= ren_en_d;
            if (|iss_en_d) begin
                iss_op    <= iss_payload.op[3:0];
                iss_pc    <= iss_payload.pc;
                iss_imm   <= iss_payload.imm;
                iss_datax <= iss_payload.datax;
                iss_datay <= iss_payload.datay;
                iss_tagx  <= iss_payload.tagx;
                iss_tagy  <= iss_payload.tagy;
                iss_tagw  <= iss_payload.tagw;
                iss_addrx <= iss_payload.addrx;
                iss_addry <= iss_payload.addry;
                iss_addrw <= iss_payload.addrw;
            end
            if (ren_en_d) begin
                ren_addr <= head_fwd.addrw;
                ren_tag  <= ren_tag_d;
            end
            if (alu_iss) begin
                rr_q <= rr_d;
            end
        end else begin
            iss_en <= '0;
            ren_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_issue_allocator.sv
// Self-checking bench: directed scenarios plus random traffic, all compared each cycle
// against a queue-based reference model of the allocator.
module tb_issue_allocator;
    localparam int NA = 2;
    localparam int NW = 3;
    localparam int D  = 4;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              rst, rdy, flush, in_valid, in_ready;
    logic [7:0]        in_op;
    logic [31:0]       in_pc, in_imm, in_datax, in_datay;
    logic [TW-1:0]     in_tagx, in_tagy, in_tagw;
    logic [4:0]        in_addrx, in_addry, in_addrw;
    logic [NW-1:0]     wb_en;
    logic [5*NW-1:0]   wb_addr;
    logic [32*NW-1:0]  wb_data;
    logic [NA-1:0]     alu_busy;
    logic              ls_busy, br_busy;
    logic [NA+1:0]     iss_en;
    logic [3:0]        iss_op;
    logic [31:0]       iss_pc, iss_imm, iss_datax, iss_datay;
    logic [TW-1:0]     iss_tagx, iss_tagy, iss_tagw;
    logic [4:0]        iss_addrx, iss_addry, iss_addrw;
    logic              ren_en;
    logic [4:0]        ren_addr;
    logic [TW-1:0]     ren_tag;

    issue_allocator #(.NUM_ALU(NA), .NUM_WB(NW), .DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_imm(in_imm), .in_datax(in_datax), .in_datay(in_datay),
        .in_tagx(in_tagx), .in_tagy(in_tagy), .in_tagw(in_tagw),
        .in_addrx(in_addrx), .in_addry(in_addry), .in_addrw(in_addrw),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_busy(alu_busy), .ls_busy(ls_busy), .br_busy(br_busy),
        .iss_en(iss_en), .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm),
        .iss_datax(iss_datax), .iss_datay(iss_datay),
        .iss_tagx(iss_tagx), .iss_tagy(iss_tagy), .iss_tagw(iss_tagw),
        .iss_addrx(iss_addrx), .iss_addry(iss_addry), .iss_addrw(iss_addrw),
        .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    op;
        logic [31:0]   pc, imm, dx, dy;
        logic [TW-1:0] tx, ty, tw;
        logic [4:0]    ax, ay, aw;
    } ent_t;

    ent_t          mq[$];
    int            rr_m;
    logic [NA+1:0] e_iss_en;
    logic          e_ren_en;
    logic [4:0]    e_ren_addr;
    logic [TW-1:0] e_ren_tag;
    ent_t          e_pay;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wb_hit(int i, logic [4:0] a, logic [TW-1:0] t);
        return wb_en[i] && wb_addr[5*i +: 5] == a && a != 0 && t != 0;
    endfunction

    function automatic ent_t fwd_m(ent_t e);
        ent_t r = e;
        for (int i = NW - 1; i >= 0; i--) begin
            if (wb_hit(i, e.ax, e.tx)) begin r.dx = wb_data[32*i +: 32]; r.tx = 0; end
            if (wb_hit(i, e.ay, e.ty)) begin r.dy = wb_data[32*i +: 32]; r.ty = 0; end
            if (wb_hit(i, e.aw, e.tw)) r.tw = 0;
        end
        return r;
    endfunction

    // 0 nop, 1 alu, 2 load, 3 store, 4 branch
    function automatic int cls_of(logic [3:0] c);
        case (c)
            4'h1, 4'h2, 4'h5, 4'hD: return 1;
            4'h9: return 2;
            4'h3: return 3;
            4'h4: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        ent_t inc, h;
        int   n0;
        bit   iss;
        if (rst) begin
            mq.delete();
            rr_m = 0; e_iss_en = 0; e_ren_en = 0; e_ren_addr = 0; e_ren_tag = 0;
            e_pay = '{default: 0};
            return;
        end
        e_iss_en = 0;
        e_ren_en = 0;
        if (!rdy) return;
        inc = fwd_m('{in_op, in_pc, in_imm, in_datax, in_datay, in_tagx, in_tagy, in_tagw,
                      in_addrx, in_addry, in_addrw});
        foreach (mq[i]) mq[i] = fwd_m(mq[i]);
        if (flush) begin
            mq.delete();
            return;
        end
        n0 = mq.size();
        if (n0 > 0) begin
            h = mq[0];
            iss = 0;
            case (cls_of(h.op[7:4]))
                0: void'(mq.pop_front());
                1: for (int j = 0; j < NA; j++) begin
                    int k = (rr_m + j) % NA;
                    if (!alu_busy[k]) begin
                        e_iss_en[k] = 1; e_ren_en = 1; e_ren_tag = TW'(k + 1);
                        e_ren_addr = h.aw; rr_m = (k + 1) % NA; iss = 1;
                        break;
                    end
                end
                2: if (!ls_busy) begin
                    e_iss_en[NA] = 1; e_ren_en = 1; e_ren_tag = TW'(NA + 1);
                    e_ren_addr = h.aw; iss = 1;
                end
                3: if (!ls_busy) begin e_iss_en[NA] = 1; h.tw = 0; iss = 1; end
                default: if (!br_busy) begin e_iss_en[NA+1] = 1; iss = 1; end
            endcase
            if (iss) begin
                e_pay = h;
                void'(mq.pop_front());
            end
        end
        if (in_valid && n0 < D) mq.push_back(inc);
    endtask

    task automatic compare_all();
        check("in_ready", in_ready, mq.size() < D);
        check("iss_en", iss_en, e_iss_en);
        check("ren_en", ren_en, e_ren_en);
        check("ren_addr", ren_addr, e_ren_addr);
        check("ren_tag", ren_tag, e_ren_tag);
        check("iss_op", iss_op, e_pay.op[3:0]);
        check("iss_pc", iss_pc, e_pay.pc);
        check("iss_imm", iss_imm, e_pay.imm);
        check("iss_datax", iss_datax, e_pay.dx);
        check("iss_datay", iss_datay, e_pay.dy);
        check("iss_tags", {iss_tagx, iss_tagy, iss_tagw}, {e_pay.tx, e_pay.ty, e_pay.tw});
        check("iss_addrs", {iss_addrx, iss_addry, iss_addrw}, {e_pay.ax, e_pay.ay, e_pay.aw});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; in_valid = 0; in_op = 0; in_pc = 0; in_imm = 0;
        in_datax = 0; in_datay = 0; in_tagx = 0; in_tagy = 0; in_tagw = 0;
        in_addrx = 0; in_addry = 0; in_addrw = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        alu_busy = 0; ls_busy = 0; br_busy = 0;
    endtask

    task automatic load_fwd(input logic [4:0] ax, input logic [31:0] exp_dx,
                            input logic [TW-1:0] exp_tx);
        ls_busy = 1; in_valid = 1; in_op = 8'h90; in_addrx = ax; in_tagx = 1;
        in_datax = 32'h1111_1111; in_addrw = 9;
        step();
        in_valid = 0;
        step();
        step();
        wb_en = 3'b001; wb_addr = 15'd3; wb_data = {64'd0, 32'hDEAD_BEEF};
        step();
        wb_en = 0; ls_busy = 0;
        step();
        check("ld_iss_en", iss_en, 4'b0100);
        check("ld_datax", iss_datax, exp_dx);
        check("ld_tagx", iss_tagx, exp_tx);
        check("ld_ren_tag", ren_tag, 3);
        step();
    endtask

    initial begin
        int accepted, next_pc, cyc;
        bit fire;
        int classes[9] = '{1, 2, 5, 13, 9, 3, 4, 0, 7};
        idle();
        rst = 1; in_valid = 1; in_op = 8'h10;
        step();
        step();
        check("rst_iss_en", iss_en, 0);
        check("rst_ren_en", ren_en, 0);
        check("rst_in_ready", in_ready, 1);
        idle();
        repeat (2) begin
            step();
            check("post_rst_idle", iss_en, 0);
        end

        // round-robin across the two ALUs
        in_valid = 1; in_op = 8'h10; in_addrw = 5;
        step();
        in_addrw = 6;
        step();
        check("rr0_en", iss_en, 4'b0001); check("rr0_tag", ren_tag, 1); check("rr0_addr", ren_addr, 5);
        in_addrw = 7;
        step();
        check("rr1_en", iss_en, 4'b0010); check("rr1_tag", ren_tag, 2); check("rr1_addr", ren_addr, 6);
        in_valid = 0;
        step();
        check("rr2_en", iss_en, 4'b0001); check("rr2_tag", ren_tag, 1); check("rr2_addr", ren_addr, 7);
        idle();

        load_fwd(5'd3, 32'hDEAD_BEEF, 0);
        idle();
        load_fwd(5'd0, 32'h1111_1111, 1);
        idle();

        // fill with stalled branches; the fifth waits at the source
        br_busy = 1; accepted = 0; next_pc = 0; in_op = 8'h40;
        for (int c = 0; c < 6; c++) begin
            in_valid = accepted < 5; in_pc = 32'(next_pc);
            fire = in_valid && in_ready;
            step();
            if (fire) begin accepted++; next_pc++; end
        end
        check("full_ready", in_ready, 0);
        check("full_accepted", accepted, 4);
        br_busy = 0; next_pc = 0; cyc = 0;
        while (next_pc < 5 && cyc < 20) begin
            in_valid = accepted < 5; in_pc = 32'(accepted);
            fire = in_valid && in_ready;
            step();
            if (fire) accepted++;
            if (iss_en[NA+1]) begin check("br_order", iss_pc, next_pc); next_pc++; end
            cyc++;
        end
        check("br_all_issued", next_pc, 5);
        idle();

        // flush while stalled, with a push in the same cycle
        alu_busy = 2'b11; in_valid = 1; in_op = 8'h20;
        repeat (3) step();
        flush = 1;
        step();
        check("flush_ready", in_ready, 1);
        idle();
        repeat (3) begin
            step();
            check("flush_no_iss", iss_en, 0);
        end

        // store frozen by rdy
        in_valid = 1; in_op = 8'h35; in_tagw = 5; in_addrw = 4;
        step();
        idle();
        rdy = 0;
        repeat (3) begin
            step();
            check("frz_iss_en", iss_en, 0);
            check("frz_ren_en", ren_en, 0);
        end
        rdy = 1;
        step();
        check("st_iss_en", iss_en, 4'b0100);
        check("st_tagw", iss_tagw, 0);
        check("st_ren_en", ren_en, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 29) == 0);
            in_valid = $urandom_range(0, 1);
            in_op = {4'(classes[$urandom_range(0, 8)]), 4'($urandom)};
            in_pc = $urandom; in_imm = $urandom; in_datax = $urandom; in_datay = $urandom;
            in_tagx = TW'($urandom); in_tagy = TW'($urandom); in_tagw = TW'($urandom);
            in_addrx = 5'($urandom_range(0, 7)); in_addry = 5'($urandom_range(0, 7));
            in_addrw = 5'($urandom_range(0, 7));
            wb_en = NW'($urandom);
            for (int i = 0; i < NW; i++) wb_addr[5*i +: 5] = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom, $urandom};
            alu_busy = NA'($urandom);
            ls_busy = ($urandom_range(0, 2) == 0);
            br_busy = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
